// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//
// Oversampling UART receiver. It recovers 8N1 / 8E1-style frames (1 start bit,
// 8 data bits LSB first, optional XOR parity bit, 1 stop bit) from an
// asynchronous serial line. Each received byte goes to the consumer over a
// valid/ready handshake, together with parity and framing error flags.
//
// Parameters
//   OVERSAMPLE  clk cycles per bit (even, >= 4)
//
// Ports
//   clk         sampling clock, OVERSAMPLE x baud rate
//   ap_rstn     asynchronous active-low reset
//   rx          serial line, asynchronous to clk, idles high
//   parity_en   1: frame carries a parity bit (hold static during a frame)
//   rx_data     received byte
//   rx_valid    rx_data and error flags are valid
//   rx_ready    consumer accepts (transfer on rx_valid & rx_ready)
//   parity_err  parity mismatch for the held byte
//   frame_err   stop bit sampled 0 for the held byte
//   overrun     one-cycle pulse when a completed frame is dropped
//   busy        receiver FSM is not idle
//
// Build option
//   UART_RX_MAJORITY_EN  each bit decision is a 2-of-3 majority of the
//                        synchronized line at MID, MID+1, MID+2 (decided at
//                        MID+2). Undefined: single sample at MID.
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       ap_rstn,
  input  logic       rx,
  input  logic       parity_en,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);

  // The start bit is decided relative to the falling edge; every later bit is
  // decided one full bit period after the previous decision (cnt wraps), so
  // the majority offset only needs to be applied here.
`ifdef UART_RX_MAJORITY_EN
  localparam logic [CNT_W-1:0] CNT_START_DEC = CNT_W'(OVERSAMPLE / 2 + 1);
`else
  localparam logic [CNT_W-1:0] CNT_START_DEC = CNT_MID;
`endif

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // Even/XOR parity of a data byte.
  function automatic logic parity8(input logic [7:0] d);
    return ^d;
  endfunction

`ifdef UART_RX_MAJORITY_EN
  // 2-of-3 majority vote.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic         sync1_q,      sync1_d;
  logic         sync2_q,      sync2_d;
  logic [1:0]   sync_vld_q,   sync_vld_d;
  logic         armed_q,      armed_d;
  state_t       state_q,      state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [2:0]   bit_idx_q,    bit_idx_d;
  logic [7:0]   shift_q,      shift_d;
  logic         par_bit_q,    par_bit_d;
  logic [7:0]   rx_data_q,    rx_data_d;
  logic         rx_valid_q,   rx_valid_d;
  logic         parity_err_q, parity_err_d;
  logic         frame_err_q,  frame_err_d;
  logic         overrun_q,    overrun_d;
  logic         busy_q,       busy_d;
`ifdef UART_RX_MAJORITY_EN
  logic [1:0]   hist_q,       hist_d;
`endif

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic rxs_s;       // synchronized line
  logic bit_smp_s;   // bit value used at a decision point
  logic commit_s;    // stop bit decision cycle: frame is complete

  assign rxs_s = sync2_q;

`ifdef UART_RX_MAJORITY_EN
  // hist_q[1] is rxs two cycles ago, hist_q[0] one cycle ago.
  assign bit_smp_s = maj3(hist_q[1], hist_q[0], rxs_s);
`else
  assign bit_smp_s = rxs_s;
`endif

  assign commit_s = (state_q == ST_STOP) && (cnt_q == CNT_LAST);

  // Synchronizer, line-valid tracking and start-detect arming.
  always_comb begin
    sync1_d    = rx;
    sync2_d    = sync1_q;
    // The synchronizer flops reset to 1, so rxs only reflects the real line
    // once two samples have been clocked through. Arming waits for that, so
    // a reset released while the line is low mid-frame cannot arm on the
    // reset value and then lock onto a data 0.
    sync_vld_d = {sync_vld_q[0], 1'b1};
    if (sync_vld_q[1] && rxs_s) begin
      armed_d = 1'b1;
    end else begin
      armed_d = armed_q;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // Two-deep history of the synchronized line for the majority vote.
  always_comb begin
    hist_d = {hist_q[0], rxs_s};
  end
`endif

  // Receive FSM: next state, bit counter, data shift and parity capture.
  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    par_bit_d = par_bit_q;

    // Free-running within a frame, wrapping every bit period.
    if (state_q != ST_IDLE) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = CNT_ZERO;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d = CNT_ZERO;
    end

    case (state_q)
      ST_IDLE: begin
        if (armed_q && !rxs_s) begin
          state_d = ST_START;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_START: begin
        if (cnt_q == CNT_START_DEC) begin
          cnt_d = CNT_ZERO;
          if (!bit_smp_s) begin
            state_d   = ST_DATA;
            bit_idx_d = 3'd0;
          end else begin
            // Line went back high before mid start bit: false start.
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_START;
        end
      end

      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          // LSB arrives first, so shift right and insert at the top.
          shift_d = {bit_smp_s, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            if (parity_en) begin
              state_d = ST_PARITY;
            end else begin
              state_d = ST_STOP;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          state_d = ST_DATA;
        end
      end

      ST_PARITY: begin
        if (cnt_q == CNT_LAST) begin
          par_bit_d = bit_smp_s;
          state_d   = ST_STOP;
        end else begin
          state_d = ST_PARITY;
        end
      end

      ST_STOP: begin
        // Leave at mid stop bit so a back-to-back start edge is not missed.
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = ST_STOP;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Output holding register: commit a finished frame or flag an overrun.
  always_comb begin
    rx_data_d    = rx_data_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = 1'b0;

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
    end

    if (commit_s) begin
      // The slot is free if empty or being emptied this very cycle; a commit
      // then wins over the handshake clear and rx_valid stays high.
      if (!rx_valid_q || rx_ready) begin
        rx_data_d    = shift_q;
        parity_err_d = parity_en & (par_bit_q != parity8(shift_q));
        frame_err_d  = ~bit_smp_s;
        rx_valid_d   = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else begin
      overrun_d = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge ap_rstn) begin
    if (!ap_rstn) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      sync_vld_q   <= 2'b00;
      armed_q      <= 1'b0;
      state_q      <= ST_IDLE;
      cnt_q        <= CNT_ZERO;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'h00;
      par_bit_q    <= 1'b0;
      rx_data_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      sync_vld_q   <= sync_vld_d;
      armed_q      <= armed_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      par_bit_q    <= par_bit_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // Majority-vote history register.
  always_ff @(posedge clk or negedge ap_rstn) begin
    if (!ap_rstn) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= hist_d;
    end
  end
`endif

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = busy_q;

endmodule

// File: doc/uart_rx.md
# uart_rx

Oversampling UART receiver that recovers 8-bit frames from a serial line driven by the team's UART transmitter. Frame format: 1 start bit (0), 8 data bits LSB first, optional parity bit (XOR of the 8 data bits), 1 stop bit (1). The receiver synchronizes the line, validates the start bit, samples each bit at mid-bit, and checks parity and framing. Each received byte goes to the downstream consumer through a valid/ready handshake, together with error flags.

## Interface
- OVERSAMPLE, 16: clk cycles per bit; even, ≥4. Internal tick counter width is clog2(OVERSAMPLE).
- clk  in  1  sampling clock, OVERSAMPLE × baud rate.
- ap_rstn  in  1  reset, asynchronous, active-low.
- rx  in  1  serial line, asynchronous to clk; idles high.
- parity_en  in  1  1: frame carries a parity bit. Must be static during a frame.
- rx_data  out  8  received byte; reset 0x00.
- rx_valid  out  1  rx_data and flags are valid; reset 0.
- rx_ready  in  1  consumer accepts; transfer occurs when rx_valid & rx_ready.
- parity_err  out  1  parity mismatch for the held byte; reset 0.
- frame_err  out  1  stop bit sampled 0 for the held byte; reset 0.
- overrun  out  1  one-cycle pulse when a completed frame is dropped; reset 0.
- busy  out  1  FSM not in IDLE; reset 0.

## Operation
- rx passes through a 2-flop synchronizer (reset value 1). All logic uses the synchronized value rxs.
- armed flag: cleared by reset and set on the first cycle rxs==1. No start is detected while not armed, so release of reset mid-frame never locks onto a data 0.
- MID = OVERSAMPLE/2−1. cnt counts 0..OVERSAMPLE−1 and wraps.
- States and transitions:
  - IDLE: when armed and rxs==0, set cnt=0 and go to START. That cycle is D.
  - START: at cnt==MID, if the sample is 0, set cnt=0, bit index=0, and go to DATA. Otherwise it is a false start: return to IDLE with no output.
  - DATA: at cnt==OVERSAMPLE−1, shift the sample into shift[7] (LSB-first shift right). After bit 7, go to PARITY if parity_en is set, otherwise go to STOP.
  - PARITY: at cnt==OVERSAMPLE−1, store the sample. Next state is STOP.
  - STOP: at cnt==OVERSAMPLE−1, sample the stop bit. Commit the frame and return to IDLE immediately, i.e. at mid stop bit, so a back-to-back start edge is caught.
- Commit rules:
  - If rx_valid==0 or rx_ready==1 in the commit cycle: load rx_data=shift, parity_err=parity_en & (stored_parity != ^shift), frame_err=~stop_sample, and set rx_valid=1.
  - Otherwise, drop the frame and pulse overrun. The held byte and its flags are unchanged.
- rx_valid clears on a handshake unless a commit occurs in the same cycle; a commit wins and rx_valid stays 1.
- Frames with errors are still delivered, with the corresponding flag set.

## Timing
- Line-to-D latency is 2–3 clk (synchronizer).
- Sample points, single-sample mode:
  - start bit: D+MID
  - data bit i: D+MID+OVERSAMPLE·(i+1)
  - parity: D+MID+9·OVERSAMPLE
  - stop: D+MID+9·OVERSAMPLE without parity, D+MID+10·OVERSAMPLE with parity
- rx_valid rises on the edge after the stop sample. For OVERSAMPLE=16 without parity, rx_valid is high from D+152.
- A byte accepted on handshake edge T: rx_valid is 0 from T+1 unless a commit occurs on T.
- An asynchronous reset mid-frame forces IDLE and all outputs to their reset values on assertion.

## Configuration
- UART_RX_MAJORITY_EN defined:
  - Each bit decision is a 2-of-3 majority of rxs at cnt==MID, MID+1, MID+2, decided at MID+2.
  - All sample/commit times above shift by +2 cycles; rx_valid for OVERSAMPLE=16 without parity is high from D+154.
  - A single-cycle glitch cannot cause a false start or a bit error.
- Undefined: single sample at cnt==MID.

## Test plan
- OVERSAMPLE=16, parity_en=0, send 0xA5, rx_ready=1. Required: rx_data=0xA5, rx_valid a 1-cycle pulse at D+152, both error flags 0.
- parity_en=1, send 0x3C with parity bit 0. Required: parity_err=0. Resend with parity bit 1. Required: parity_err=1, rx_data=0x3C.
- Send 0x55 with stop bit 0. Required: frame_err=1, rx_data=0x55.
- rx_ready=0, two back-to-back frames 0x11 then 0x22. Required: rx_data stays 0x11, overrun pulses once at the second commit. Then rx_ready=1. Required: 0x11 accepted, rx_valid drops.
- 3-cycle low glitch on rx while idle. Required: START entered, then return to IDLE, rx_valid stays 0.
- Assert ap_rstn low during data bit 3 and release during a 0 bit. Required: no frame output until the line returns high and a full frame 0xC3 is then received correctly.
